sqrt_sequencer: RTL and testbench
=================================

// Module: sqrt_sequencer
// PURPOSE
//   Control FSM for the digit-by-digit (restoring) integer square root. Owns the
//   remainder/root registers and sequences one external shared CLA adder, one
//   root bit per cycle. Sits between the keypressed enable pulse (start) and the
//   display mux. Provides a start/busy/valid_bit handshake.
// PARAMETERS
//   ROOT_WIDTH  8   root bits; radicand is 2*ROOT_WIDTH bits, remainder ROOT_WIDTH+1
//   ADD_W       11  adder width, fixed at ROOT_WIDTH+3; any other value is illegal
// PORTS
//   clk         in   1             single clock, all logic on posedge
//   reset       in   1             synchronous, active-high
//   start       in   1             one-cycle request; sampled in IDLE/DONE only
//   radicand    in   2*ROOT_WIDTH  operand, captured on accepted start
//   busy        out  1             high while state==ITER
//   valid_bit   out  1             high while state==DONE
//   root        out  ROOT_WIDTH    result, valid when valid_bit
//   remainder   out  ROOT_WIDTH+1  radicand - root*root, valid when valid_bit
//   add_a       out  ADD_W         adder operand A (shifted partial remainder)
//   add_b       out  ADD_W         adder operand B (~trial)
//   add_cin     out  1             adder carry-in (1 = subtract)
//   add_sum     in   ADD_W         adder sum, combinational, same cycle
//   add_cout    in   1             adder carry-out; 1 = no borrow (A >= trial)
// BEHAVIOUR
//   Reset (sync, any state): state=IDLE; busy=0, valid_bit=0, root=0,
//     remainder=0, count=0, captured radicand=0; adder ports idle (see below).
//   States: IDLE, ITER, DONE (2-bit encoding, no other reachable states).
//   IDLE: start=1 -> capture radicand, clear root/remainder, count=ROOT_WIDTH-1,
//     go ITER. start=0 -> stay.
//   ITER, per cycle, i=count:
//     pair    = radicand[2i+1:2i]
//     shifted = {remainder, pair} zero-extended to ADD_W
//     trial   = {root, 2'b01} zero-extended to ADD_W
//     drive add_a=shifted, add_b=~trial, add_cin=1
//     add_cout=1: remainder<=add_sum[ROOT_WIDTH:0]; root<={root[ROOT_WIDTH-2:0],1}
//     add_cout=0: remainder<=shifted[ROOT_WIDTH:0]; root<={root[ROOT_WIDTH-2:0],0}
//     count==0 -> go DONE; else count<=count-1. start ignored in ITER.
//   DONE: valid_bit=1; root/remainder held stable indefinitely.
//     start=1 -> same as IDLE accept (recapture, go ITER, valid_bit drops next cycle).
//   Latency: start accepted at edge k -> valid_bit=1 after edge k+ROOT_WIDTH
//     (8 cycles at default). Throughput one op per ROOT_WIDTH+1 cycles back-to-back.
//   Adder idle (IDLE/DONE): add_a=0, add_b=0, add_cin=0.
//   Outputs are registered except add_a/add_b/add_cin (decoded from state/regs).
//   Remainder always fits ROOT_WIDTH+1 bits (max 2*root); add_sum upper bits
//     are zero when add_cout=1, so the truncation is lossless.
//   Reset asserted mid-ITER: abort; next cycle IDLE, all outputs at reset values.
//   reset and start in the same cycle: reset wins, start is dropped.
//   radicand changing during ITER has no effect (captured copy is used).
// TESTING
//   radicand=16'd144, start pulse -> busy 8 cycles, then valid_bit=1, root=12,
//     remainder=0.
//   radicand=16'hFFFF -> root=255, remainder=510; radicand=16'd0 -> root=0, rem=0.
//   radicand=16'd200 -> root=14, remainder=4; start re-pulsed during ITER with
//     radicand=16'd9 -> ignored, result unchanged.
//   From DONE, start with radicand=16'd99 -> valid_bit=0 next cycle, 8 cycles
//     later root=9, remainder=18.
//   reset pulsed on 4th ITER cycle -> IDLE next cycle, busy=0, valid_bit=0,
//     root=0, remainder=0; subsequent start with 16'd1 -> root=1, rem=0.
//   Exhaustive sweep 0..65535 vs model (root=floor(sqrt(x)), rem=x-root^2), plus
//     check add_cin/add_a/add_b are zero in IDLE and DONE.

Source files
------------

// File: rtl/sqrt_sequencer.sv
// Restoring digit-by-digit integer square root sequencer: one root bit per cycle through an external shared adder.
// Result is valid ROOT_WIDTH cycles after start; start is ignored while busy.
module sqrt_sequencer #(
   parameter int ROOT_WIDTH = 8,
   parameter int ADD_W      = ROOT_WIDTH + 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [2*ROOT_WIDTH-1:0] radicand,
   output logic                    busy,
   output logic                    valid_bit,
   output logic [ROOT_WIDTH-1:0]   root,
   output logic [ROOT_WIDTH:0]     remainder,
   output logic [ADD_W-1:0]        add_a,
   output logic [ADD_W-1:0]        add_b,
   output logic                    add_cin,
   input  logic [ADD_W-1:0]        add_sum,
   input  logic                    add_cout
);

   localparam int CW = (ROOT_WIDTH > 1) ? $clog2(ROOT_WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [2*ROOT_WIDTH-1:0]   rad_q, rad_d;
   logic [ROOT_WIDTH-1:0]     root_q, root_d;
   logic [ROOT_WIDTH:0]       rem_q, rem_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic                      busy_q, busy_d;
   logic                      valid_q, valid_d;

   logic [1:0]                pair;
   logic [ADD_W-1:0]          shifted;
   logic [ADD_W-1:0]          trial;
   logic                      unused_sum_hi;

   // Widths below assume ADD_W == ROOT_WIDTH+3; the remainder never exceeds 2*root.
   assign pair          = rad_q[{cnt_q, 1'b0} +: 2];
   assign shifted       = {rem_q, pair};
   assign trial         = {1'b0, root_q, 2'b01};
   assign unused_sum_hi = ^add_sum[ADD_W-1:ROOT_WIDTH+1];

   always_comb begin
      state_d = state_q;
      rad_d   = rad_q;
      root_d  = root_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               rad_d   = radicand;
               root_d  = '0;
               rem_d   = '0;
               cnt_d   = CW'(ROOT_WIDTH - 1);
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            add_a   = shifted;
            add_b   = ~trial;
            add_cin = 1'b1;
            if (add_cout) begin
               rem_d  = add_sum[ROOT_WIDTH:0];
               root_d = {root_q[ROOT_WIDTH-2:0], 1'b1};
            end else begin
               rem_d  = shifted[ROOT_WIDTH:0];
               root_d = {root_q[ROOT_WIDTH-2:0], 1'b0};
            end
            if (cnt_q == '0) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d  = (state_d == S_ITER);
      valid_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         rad_q   <= '0;
         root_q  <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rad_q   <= rad_d;
         root_q  <= root_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   assign busy      = busy_q;
   assign valid_bit = valid_q;
   assign root      = root_q;
   assign remainder = rem_q;

endmodule

// File: tb/tb_sqrt_sequencer.sv
// Bench for sqrt_sequencer: models the external adder, applies a vector table,
// hand-written corner sequences and random operands checked against a floor-sqrt model.
module tb_sqrt_sequencer;

   localparam int RW = 8;
   localparam int AW = RW + 3;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [2*RW-1:0] radicand;
   logic            busy;
   logic            valid_bit;
   logic [RW-1:0]   root;
   logic [RW:0]     remainder;
   logic [AW-1:0]   add_a;
   logic [AW-1:0]   add_b;
   logic            add_cin;
   logic [AW-1:0]   add_sum;
   logic            add_cout;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // External shared adder
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{AW{1'b0}}, add_cin};

   sqrt_sequencer #(.ROOT_WIDTH(RW), .ADD_W(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .radicand  (radicand),
      .busy      (busy),
      .valid_bit (valid_bit),
      .root      (root),
      .remainder (remainder),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_sum   (add_sum),
      .add_cout  (add_cout)
   );

   typedef struct {
      logic [15:0] x;
      logic [7:0]  r;
      logic [8:0]  m;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic int model_root(input int x);
      int r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      return r;
   endfunction

   task automatic chk_adder_idle(input string tag);
      chk({tag, " add_a idle"},   32'(add_a),   32'd0);
      chk({tag, " add_b idle"},   32'(add_b),   32'd0);
      chk({tag, " add_cin idle"}, 32'(add_cin), 32'd0);
   endtask

   // Pulse start with x; optionally re-pulse start with a decoy mid-operation.
   // Returns with outputs sampled on the first negedge where valid_bit is high.
   task automatic run_op(input logic [15:0] x, input bit full_checks, input bit decoy);
      int cyc;
      int nbusy;
      @(negedge clk);
      start    = 1'b1;
      radicand = x;
      @(negedge clk);
      start    = 1'b0;
      radicand = $urandom_range(0, 65535);
      if (full_checks) begin
         chk("valid_bit drops after accept", 32'(valid_bit), 32'd0);
         chk("first-iter add_cin", 32'(add_cin), 32'd1);
         chk("first-iter add_b", 32'(add_b), 32'h7FE);
         chk("first-iter add_a", 32'(add_a), 32'(x[15:14]));
      end
      cyc   = 0;
      nbusy = 0;
      while (!valid_bit && cyc < 20) begin
         if (busy) nbusy++;
         if (decoy && cyc == 2) begin
            start    = 1'b1;
            radicand = 16'd9;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      if (!valid_bit) begin
         chk("valid_bit timeout", 32'd0, 32'd1);
      end
      if (full_checks) begin
         chk("latency", 32'(cyc), 32'(RW));
         chk("busy cycles", 32'(nbusy), 32'(RW));
         chk("busy low in DONE", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      tbl[0]  = '{16'd144,   8'd12,  9'd0};
      tbl[1]  = '{16'hFFFF,  8'd255, 9'd510};
      tbl[2]  = '{16'd0,     8'd0,   9'd0};
      tbl[3]  = '{16'd200,   8'd14,  9'd4};
      tbl[4]  = '{16'd99,    8'd9,   9'd18};
      tbl[5]  = '{16'd1,     8'd1,   9'd0};
      tbl[6]  = '{16'd2,     8'd1,   9'd1};
      tbl[7]  = '{16'd3,     8'd1,   9'd2};
      tbl[8]  = '{16'd255,   8'd15,  9'd30};
      tbl[9]  = '{16'd256,   8'd16,  9'd0};
      tbl[10] = '{16'd65024, 8'd254, 9'd508};
      tbl[11] = '{16'd65025, 8'd255, 9'd0};

      reset    = 1'b1;
      start    = 1'b0;
      radicand = '0;
      repeat (3) @(negedge clk);
      chk("reset busy",      32'(busy),      32'd0);
      chk("reset valid_bit", 32'(valid_bit), 32'd0);
      chk("reset root",      32'(root),      32'd0);
      chk("reset remainder", 32'(remainder), 32'd0);
      chk_adder_idle("reset");
      reset = 1'b0;
      @(negedge clk);
      chk_adder_idle("idle");

      // Table: back-to-back from DONE after the first entry
      for (int i = 0; i < 12; i++) begin
         run_op(tbl[i].x, 1'b1, 1'b0);
         chk($sformatf("tbl%0d root", i),      32'(root),      32'(tbl[i].r));
         chk($sformatf("tbl%0d remainder", i), 32'(remainder), 32'(tbl[i].m));
         chk_adder_idle("done");
         @(negedge clk);
         chk($sformatf("tbl%0d root held", i), 32'(root), 32'(tbl[i].r));
      end

      // Start re-pulsed mid-iteration is ignored
      run_op(16'd200, 1'b1, 1'b1);
      chk("decoy root",      32'(root),      32'd14);
      chk("decoy remainder", 32'(remainder), 32'd4);

      // Reset together with start on the 4th iteration cycle
      @(negedge clk);
      start    = 1'b1;
      radicand = 16'hFFFF;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset    = 1'b1;
      start    = 1'b1;
      radicand = 16'd50;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      chk("abort busy",      32'(busy),      32'd0);
      chk("abort valid_bit", 32'(valid_bit), 32'd0);
      chk("abort root",      32'(root),      32'd0);
      chk("abort remainder", 32'(remainder), 32'd0);
      chk_adder_idle("abort");
      @(negedge clk);
      chk("start dropped busy", 32'(busy), 32'd0);
      run_op(16'd1, 1'b1, 1'b0);
      chk("post-abort root",      32'(root),      32'd1);
      chk("post-abort remainder", 32'(remainder), 32'd0);

      // Random operands, with random idle gaps in DONE
      for (int i = 0; i < 2500; i++) begin
         int x;
         int r;
         x = (i % 8 == 0) ? int'($urandom_range(65000, 65535)) : int'($urandom_range(0, 65535));
         r = model_root(x);
         run_op(16'(x), 1'b0, 1'b0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         chk($sformatf("rand x=%0d root", x),      32'(root),      32'(r));
         chk($sformatf("rand x=%0d remainder", x), 32'(remainder), 32'(x - r * r));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
